// File: rtl/lsq_pkg.sv
// lsq_pkg: shared LSQ sizing constants, tag type and wrapped-occupancy helper
package lsq_pkg;

    localparam int LSQ_DEPTH = 32;
    localparam int LSQ_AW    = 5;

    // {wrap, index}; the wrap bit distinguishes full from empty when indices match
    typedef logic [LSQ_AW:0] lsq_tag_t;

    function automatic lsq_tag_t lsq_occ(input lsq_tag_t tail, input lsq_tag_t head);
        return tail - head;
    endfunction

endpackage

// File: rtl/lsq_alloc_prefix.sv
// lsq_alloc_prefix: slot-ordered tag offsets and request count for three slots
module lsq_alloc_prefix (
    input  logic [2:0] req,
    output logic [1:0] off0,
    output logic [1:0] off1,
    output logic [1:0] off2,
    output logic [1:0] nreq
);

    // Each slot's offset is the number of enabled slots ahead of it
    always_comb begin
        off0 = 2'd0;
        off1 = {1'b0, req[0]};
        off2 = {1'b0, req[0]} + {1'b0, req[1]};
        nreq = off2 + {1'b0, req[2]};
    end

endmodule

// File: rtl/lsq_alloc.sv
// lsq_alloc: in-order LSQ tag allocator with retirement, flush rewind and overflow error
module lsq_alloc
    import lsq_pkg::*;
#(
    parameter int DEPTH = LSQ_DEPTH,
    parameter int AW    = LSQ_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          except,
    input  logic          req0_en,
    input  logic          req1_en,
    input  logic          req2_en,
    input  logic [1:0]    ret_cnt,
    output logic          do_stall,
    output logic          p0_en,
    output logic          p1_en,
    output logic          p2_en,
    output logic [AW:0]   p0_LSQ,
    output logic [AW:0]   p1_LSQ,
    output logic [AW:0]   p2_LSQ,
    output logic [AW:0]   head_out,
    output logic [AW:0]   tail_out,
    output logic [AW:0]   free_cnt,
    output logic          empty,
    output logic          full,
    output logic          err
);

    logic [AW:0] head, tail, occ, head_nxt;
    logic [1:0]  off0, off1, off2, nreq;
    logic [2:0]  req;
    logic        grant, over;

    assign req      = {req2_en, req1_en, req0_en};
    assign head_out = head;
    assign tail_out = tail;

    lsq_alloc_prefix u_prefix (
        .req  (req),
        .off0 (off0),
        .off1 (off1),
        .off2 (off2),
        .nreq (nreq)
    );

    // Status from registered pointers only; retirement this cycle never frees room early
    always_comb begin
        occ      = lsq_occ(tail, head);
        free_cnt = (AW+1)'(DEPTH) - occ;
        empty    = occ == '0;
        full     = occ == (AW+1)'(DEPTH);
        do_stall = (AW+1)'(nreq) > free_cnt;
        grant    = !stall && !except && !do_stall && nreq != 2'd0;
        over     = (AW+1)'(ret_cnt) > occ;
        head_nxt = head + (over ? occ : (AW+1)'(ret_cnt));
    end

    // Pointers, sticky error and one-cycle grant registers; a flush rewinds tail to the new head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head   <= '0;
            tail   <= '0;
            err    <= 1'b0;
            p0_en  <= 1'b0;
            p1_en  <= 1'b0;
            p2_en  <= 1'b0;
            p0_LSQ <= '0;
            p1_LSQ <= '0;
            p2_LSQ <= '0;
        end else begin
            head   <= head_nxt;
            tail   <= except ? head_nxt : grant ? tail + (AW+1)'(nreq) : tail;
            err    <= err | over;
            p0_en  <= grant & req[0];
            p1_en  <= grant & req[1];
            p2_en  <= grant & req[2];
            p0_LSQ <= (grant & req[0]) ? tail + (AW+1)'(off0) : '0;
            p1_LSQ <= (grant & req[1]) ? tail + (AW+1)'(off1) : '0;
            p2_LSQ <= (grant & req[2]) ? tail + (AW+1)'(off2) : '0;
        end
    end

endmodule

// File: tb/tb_lsq_alloc.sv
// tb_lsq_alloc: directed scoreboard bench for the LSQ allocator
module tb_lsq_alloc;

    typedef struct packed {
        logic [2:0] en;
        logic [5:0] t0;
        logic [5:0] t1;
        logic [5:0] t2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, stall, except, req0_en, req1_en, req2_en;
    logic [1:0] ret_cnt;
    logic       do_stall, p0_en, p1_en, p2_en, empty, full, err;
    logic [5:0] p0_LSQ, p1_LSQ, p2_LSQ, head_out, tail_out, free_cnt;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    lsq_alloc dut (
        .clk      (clk),
        .rst      (rst_n),
        .stall    (stall),
        .except   (except),
        .req0_en  (req0_en),
        .req1_en  (req1_en),
        .req2_en  (req2_en),
        .ret_cnt  (ret_cnt),
        .do_stall (do_stall),
        .p0_en    (p0_en),
        .p1_en    (p1_en),
        .p2_en    (p2_en),
        .p0_LSQ   (p0_LSQ),
        .p1_LSQ   (p1_LSQ),
        .p2_LSQ   (p2_LSQ),
        .head_out (head_out),
        .tail_out (tail_out),
        .free_cnt (free_cnt),
        .empty    (empty),
        .full     (full),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] r, input logic [1:0] ret, input logic st, input logic ex);
        {req2_en, req1_en, req0_en} = r;
        ret_cnt = ret;
        stall   = st;
        except  = ex;
        #1;
    endtask

    // Advance one cycle with the current inputs, then expect that grant on the following negedge
    task automatic grant_cyc(input logic [2:0] en, input logic [5:0] t0, input logic [5:0] t1, input logic [5:0] t2);
        cyc();
        q.push_back('{en: en, t0: t0, t1: t1, t2: t2});
    endtask

    // Monitor: every grant must match the oldest expectation; grants with none pending are errors
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("grant_en", {29'd0, p2_en, p1_en, p0_en}, {29'd0, e.en});
            chk("p0_LSQ", {26'd0, p0_LSQ}, {26'd0, e.t0});
            chk("p1_LSQ", {26'd0, p1_LSQ}, {26'd0, e.t1});
            chk("p2_LSQ", {26'd0, p2_LSQ}, {26'd0, e.t2});
        end else if (p0_en || p1_en || p2_en) begin
            chk("unexpected_grant", {29'd0, p2_en, p1_en, p0_en}, 32'd0);
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(3'b000, 2'd0, 1'b0, 1'b0);
        chk("rst_head", head_out, 0);
        chk("rst_tail", tail_out, 0);
        chk("rst_free", free_cnt, 32);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        chk("rst_do_stall", do_stall, 0);
        chk("rst_p0_en", p0_en, 0);
        #12 rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 10; i++) begin
            drive(3'b111, 2'd0, 1'b0, 1'b0);
            chk("fill_free", free_cnt, 32 - 3 * i);
            chk("fill_do_stall", do_stall, 0);
            grant_cyc(3'b111, 6'(3 * i), 6'(3 * i + 1), 6'(3 * i + 2));
        end
        drive(3'b111, 2'd0, 1'b0, 1'b0);
        chk("free_at_2", free_cnt, 2);
        chk("do_stall_3_of_2", do_stall, 1);
        cyc();
        chk("tail_held_stall", tail_out, 30);
        drive(3'b001, 2'd0, 1'b0, 1'b0);
        chk("do_stall_1_of_2", do_stall, 0);
        grant_cyc(3'b001, 6'd30, 6'd0, 6'd0);
        drive(3'b001, 2'd0, 1'b0, 1'b0);
        chk("tail_31", tail_out, 31);
        chk("full_at_31", full, 0);
        grant_cyc(3'b001, 6'd31, 6'd0, 6'd0);
        drive(3'b001, 2'd3, 1'b0, 1'b0);
        chk("full_at_32", full, 1);
        chk("free_at_32", free_cnt, 0);
        chk("tail_32", tail_out, 32);
        chk("do_stall_full_retiring", do_stall, 1);
        cyc();
        chk("head_after_ret3", head_out, 3);
        chk("full_cleared", full, 0);
        drive(3'b111, 2'd3, 1'b0, 1'b0);
        grant_cyc(3'b111, 6'd32, 6'd33, 6'd34);
        chk("wrap_tail", tail_out, 35);
        chk("wrap_head", head_out, 6);
        chk("wrap_free", free_cnt, 3);
        drive(3'b000, 2'd3, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cyc();
        chk("drain_head", head_out, 33);
        chk("drain_empty_pre", empty, 0);
        drive(3'b000, 2'd2, 1'b0, 1'b0);
        cyc();
        drive(3'b000, 2'd0, 1'b0, 1'b0);
        chk("drain_empty", empty, 1);
        chk("drain_free", free_cnt, 32);
        chk("drain_err", err, 0);

        rst_n = 1'b0;
        #1;
        chk("rst2_tail", tail_out, 0);
        #3 rst_n = 1'b1;
        drive(3'b111, 2'd0, 1'b0, 1'b0);
        grant_cyc(3'b111, 6'd0, 6'd1, 6'd2);
        drive(3'b011, 2'd0, 1'b0, 1'b0);
        grant_cyc(3'b011, 6'd3, 6'd4, 6'd0);
        drive(3'b110, 2'd0, 1'b0, 1'b0);
        chk("sparse_tail5", tail_out, 5);
        grant_cyc(3'b110, 6'd0, 6'd5, 6'd6);
        drive(3'b101, 2'd0, 1'b0, 1'b0);
        chk("sparse_tail7", tail_out, 7);
        grant_cyc(3'b101, 6'd7, 6'd0, 6'd8);
        drive(3'b010, 2'd0, 1'b0, 1'b0);
        grant_cyc(3'b010, 6'd0, 6'd9, 6'd0);

        drive(3'b111, 2'd2, 1'b0, 1'b1);
        chk("except_occ", 32 - free_cnt, 10);
        cyc();
        drive(3'b000, 2'd0, 1'b0, 1'b0);
        chk("except_head", head_out, 2);
        chk("except_tail", tail_out, 2);
        chk("except_empty", empty, 1);

        drive(3'b111, 2'd0, 1'b1, 1'b0);
        chk("stall_do_stall", do_stall, 0);
        cyc();
        cyc();
        chk("stall_tail", tail_out, 2);
        drive(3'b111, 2'd0, 1'b0, 1'b0);
        grant_cyc(3'b111, 6'd2, 6'd3, 6'd4);
        drive(3'b000, 2'd2, 1'b0, 1'b0);
        chk("release_tail", tail_out, 5);
        cyc();
        drive(3'b000, 2'd3, 1'b0, 1'b0);
        chk("pre_err_head", head_out, 4);
        chk("pre_err", err, 0);
        cyc();
        drive(3'b000, 2'd0, 1'b0, 1'b0);
        chk("over_head", head_out, 5);
        chk("over_err", err, 1);
        cyc();
        cyc();
        chk("err_sticky", err, 1);

        drive(3'b111, 2'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst3_err", err, 0);
        chk("rst3_tail", tail_out, 0);
        cyc();
        cyc();
        chk("lost_grant", {29'd0, p2_en, p1_en, p0_en}, 0);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
